// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state/sel encodings and control decode for the restoring divider
// Shared by the divider controller, its datapath and the benches of both.
package div_pkg;

  localparam int DIV_NBITS = 8;
  localparam int DIV_DW    = 7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_SUB   = 3'd3;
  localparam logic [2:0] ST_TEST  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] SEL_SUB  = 2'b00;
  localparam logic [1:0] SEL_ADD  = 2'b01;
  localparam logic [1:0] SEL_SETQ = 2'b10;

  typedef struct packed {
    logic       load;
    logic       add;
    logic       shift;
    logic       inbit;
    logic [1:0] sel;
  } dp_ctrl_t;

  // TEST either restores the remainder or sets the new quotient bit, never both.
  function automatic dp_ctrl_t decode_ctrl(input logic [2:0] st, input logic sign);
    dp_ctrl_t c;
    c = '0;
    case (st)
      ST_LOAD:  c.load  = 1'b1;
      ST_SHIFT: c.shift = 1'b1;
      ST_SUB: begin
        c.add = 1'b1;
        c.sel = SEL_SUB;
      end
      ST_TEST: begin
        c.add = 1'b1;
        if (sign) begin
          c.sel = SEL_ADD;
        end else begin
          c.sel   = SEL_SETQ;
          c.inbit = 1'b1;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/divider_control_if.sv
// rtl/divider_control_if.sv - control/status bus between divider controller and datapath
// The controller is the master; the datapath owns divisorin and the remainder sign.
interface divider_control_if;
  import div_pkg::*;

  logic [DIV_DW-1:0] divisorin;
  logic              sign;
  logic              load;
  logic              add;
  logic              shift;
  logic              inbit;
  logic [1:0]        sel;

  modport master (
    input  divisorin,
    input  sign,
    output load,
    output add,
    output shift,
    output inbit,
    output sel
  );

  modport slave (
    output divisorin,
    output sign,
    input  load,
    input  add,
    input  shift,
    input  inbit,
    input  sel
  );

endinterface

// File: rtl/divider_control.sv
// rtl/divider_control.sv - FSM sequencing a restoring shift/subtract divider datapath
// One LOAD cycle, then SHIFT/SUB/TEST per quotient bit, then a one-cycle DONE.
module divider_control
  import div_pkg::*;
#(
  parameter int NBITS = DIV_NBITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  divider_control_if.master dp,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int CW = $clog2(NBITS + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_zero_q, div_zero_d;
  logic          last_iter;
  dp_ctrl_t      ctrl;

  assign last_iter = (cnt_q == CW'(NBITS - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero divisor skips the datapath entirely and reports via div_zero.
          if (dp.divisorin == '0) begin
            state_d    = ST_DONE;
            div_zero_d = 1'b1;
          end else begin
            state_d    = ST_LOAD;
            div_zero_d = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: state_d = ST_SUB;
      ST_SUB:   state_d = ST_TEST;
      ST_TEST: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = last_iter ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign ctrl = decode_ctrl(state_q, dp.sign);

  assign dp.load  = ctrl.load;
  assign dp.add   = ctrl.add;
  assign dp.shift = ctrl.shift;
  assign dp.inbit = ctrl.inbit;
  assign dp.sel   = ctrl.sel;

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_SHIFT) ||
                    (state_q == ST_SUB)  || (state_q == ST_TEST);
  assign done     = (state_q == ST_DONE);
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_divider_control.sv
// tb/tb_divider_control.sv - scoreboard bench for divider_control with a behavioural datapath
// The bench plays the datapath; results are checked against integer division.
module tb_divider_control;
  import div_pkg::*;

  typedef struct {
    logic [7:0] q;
    logic [6:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic div_zero;
  logic [7:0] dividend;

  int         rem_q;
  logic [7:0] quo_q;
  logic [6:0] dvs_q;

  exp_t sb[$];
  int checks;
  int errors;
  int n_load, n_add, n_shift, n_setq, n_restore, n_bad;

  divider_control_if dpi ();

  divider_control #(.NBITS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dp       (dpi),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural restoring-division datapath driven by the controller's pins.
  always @(posedge clk) begin
    if (dpi.load) begin
      rem_q <= 0;
      quo_q <= dividend;
      dvs_q <= dpi.divisorin;
    end else begin
      if (dpi.shift) begin
        rem_q <= rem_q * 2 + int'(quo_q[7]);
        quo_q <= {quo_q[6:0], dpi.inbit};
      end
      if (dpi.add) begin
        case (dpi.sel)
          SEL_SUB:  rem_q <= rem_q - int'(dvs_q);
          SEL_ADD:  rem_q <= rem_q + int'(dvs_q);
          SEL_SETQ: quo_q[0] <= dpi.inbit;
          default:  ;
        endcase
      end
    end
  end
  assign dpi.sign = (rem_q < 0);

  task automatic push_exp(input logic [7:0] a, input logic [6:0] b, input int lat);
    exp_t e;
    e.lat = lat;
    if (b == 7'd0) begin
      e.dz = 1'b1;
      e.q  = '0;
      e.r  = '0;
    end else begin
      e.dz = 1'b0;
      e.q  = 8'(a / b);
      e.r  = 7'(a % b);
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] a, input logic [6:0] b);
    @(negedge clk);
    dividend      = a;
    dpi.divisorin = b;
    start         = 1'b1;
    push_exp(a, b, (b == 7'd0) ? 1 : 26);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    n_load = 0; n_add = 0; n_shift = 0; n_setq = 0; n_restore = 0; n_bad = 0;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (dpi.load)  n_load++;
      if (dpi.shift) n_shift++;
      if (dpi.add)   n_add++;
      if (dpi.add && dpi.sel == SEL_SETQ) n_setq++;
      if (dpi.add && dpi.sel == SEL_ADD)  n_restore++;
      if (dpi.add && dpi.sel == 2'b11)    n_bad++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, done, div_zero, dpi.load, dpi.add, dpi.shift, dpi.inbit, dpi.sel} !== 9'b0) begin
        errors++;
        $display("FAIL reset_hold: outputs %b expected 000000000",
                 {busy, done, div_zero, dpi.load, dpi.add, dpi.shift, dpi.inbit, dpi.sel});
      end
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, done, div_zero, dpi.load, dpi.add, dpi.shift, dpi.inbit, dpi.sel} !== 9'b0) begin
        errors++;
        $display("FAIL idle_after_reset: outputs %b expected 000000000",
                 {busy, done, div_zero, dpi.load, dpi.add, dpi.shift, dpi.inbit, dpi.sel});
      end
    end
  endtask

  task automatic test_divide();
    logic [7:0] ta [8];
    logic [6:0] tb [8];
    int cyc;
    bit ok;
    exp_t e;
    ta[0] = 8'd200; tb[0] = 7'd7;
    ta[1] = 8'd255; tb[1] = 7'd1;
    ta[2] = 8'd5;   tb[2] = 7'd9;
    ta[3] = 8'd0;   tb[3] = 7'd127;
    for (int i = 4; i < 8; i++) begin
      ta[i] = 8'($urandom_range(0, 255));
      tb[i] = 7'($urandom_range(1, 127));
    end
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i]);
      wait_done(cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL div_timeout %0d/%0d: no done within %0d cycles", ta[i], tb[i], cyc);
      end
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL div_latency %0d/%0d: got %0d expected %0d", ta[i], tb[i], cyc, e.lat);
      end
      checks++;
      if (quo_q !== e.q) begin
        errors++;
        $display("FAIL div_quotient %0d/%0d: got %b expected %b", ta[i], tb[i], quo_q, e.q);
      end
      checks++;
      if (7'(rem_q) !== e.r || rem_q < 0) begin
        errors++;
        $display("FAIL div_remainder %0d/%0d: got %0d expected %0d", ta[i], tb[i], rem_q, e.r);
      end
      checks++;
      if (div_zero !== e.dz || busy !== 1'b0) begin
        errors++;
        $display("FAIL div_flags %0d/%0d: div_zero=%b busy=%b expected div_zero=%b busy=0",
                 ta[i], tb[i], div_zero, busy, e.dz);
      end
      checks++;
      if (n_setq !== $countones(e.q) || n_restore !== 8 - $countones(e.q)) begin
        errors++;
        $display("FAIL div_test_sel %0d/%0d: setq=%0d restore=%0d expected setq=%0d restore=%0d",
                 ta[i], tb[i], n_setq, n_restore, $countones(e.q), 8 - $countones(e.q));
      end
      checks++;
      if (n_load !== 1 || n_shift !== 8 || n_add !== 16 || n_bad !== 0) begin
        errors++;
        $display("FAIL div_pulses %0d/%0d: load=%0d shift=%0d add=%0d sel11=%0d expected 1 8 16 0",
                 ta[i], tb[i], n_load, n_shift, n_add, n_bad);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    bit ok;
    exp_t e;
    issue(8'd77, 7'd0);
    wait_done(cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc !== e.lat) begin
      errors++;
      $display("FAIL dz_latency: got %0d (seen=%0d) expected %0d", cyc, ok, e.lat);
    end
    checks++;
    if (div_zero !== e.dz || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_flag: div_zero=%b busy=%b expected div_zero=1 busy=0", div_zero, busy);
    end
    checks++;
    if (n_load !== 0 || n_add !== 0 || n_shift !== 0) begin
      errors++;
      $display("FAIL dz_no_datapath: load=%0d add=%0d shift=%0d expected 0 0 0", n_load, n_add, n_shift);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (div_zero !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL dz_hold: div_zero=%b done=%b expected div_zero=1 done=0", div_zero, done);
    end
    issue(8'd200, 7'd7);
    @(negedge clk);
    checks++;
    if (div_zero !== 1'b0 || dpi.load !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dz_clear_on_start: div_zero=%b load=%b busy=%b expected 0 1 1", div_zero, dpi.load, busy);
    end
    wait_done(cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc + 1 !== e.lat || quo_q !== e.q || 7'(rem_q) !== e.r) begin
      errors++;
      $display("FAIL dz_followup: cyc=%0d q=%b r=%0d expected cyc=%0d q=%b r=%0d",
               cyc + 1, quo_q, rem_q, e.lat, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    exp_t e;
    issue(8'd200, 7'd7);
    // cycle 12 falls inside the fourth iteration
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b expected 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, dpi.load, dpi.add, dpi.shift, dpi.inbit, dpi.sel} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: outputs %b expected 000000000",
               {busy, done, div_zero, dpi.load, dpi.add, dpi.shift, dpi.inbit, dpi.sel});
    end
    reset = 1'b0;
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_stays_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    issue(8'd200, 7'd7);
    wait_done(cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc !== e.lat || quo_q !== e.q || 7'(rem_q) !== e.r || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: cyc=%0d q=%b r=%0d dz=%b expected cyc=%0d q=%b r=%0d dz=0",
               cyc, quo_q, rem_q, div_zero, e.lat, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int extra;
    bit ok;
    exp_t e;
    @(negedge clk);
    dividend      = 8'd200;
    dpi.divisorin = 7'd7;
    start         = 1'b1;
    push_exp(8'd200, 7'd7, 26);
    push_exp(8'd200, 7'd7, 27);
    for (int op = 0; op < 2; op++) begin
      wait_done(cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || cyc !== e.lat) begin
        errors++;
        $display("FAIL b2b_latency op%0d: got %0d expected %0d", op, cyc, e.lat);
      end
      checks++;
      if (quo_q !== e.q || 7'(rem_q) !== e.r || n_load !== 1) begin
        errors++;
        $display("FAIL b2b_result op%0d: q=%b r=%0d loads=%0d expected q=%b r=%0d loads=1",
                 op, quo_q, rem_q, n_load, e.q, e.r);
      end
    end
    start = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_no_third_op: active cycles=%0d expected 0", extra);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    start         = 1'b0;
    dividend      = '0;
    dpi.divisorin = '0;
    test_reset();
    test_divide();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_control.md
DIVIDER_CONTROL -- requirements
Module: divider_control

Interface
REQ-001 SHALL have parameter NBITS, default 8, number of quotient bits (iterations) per division.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new division; sampled only in IDLE.
REQ-005 SHALL have port divisorin  input  7  same divisor bus driven to the datapath; used only to detect zero.
REQ-006 SHALL have port sign  input  1  datapath remainder sign; 1 = last subtraction went negative.
REQ-007 SHALL have ports load, add, shift, inbit (output, 1 each) and sel (output, 2), all driving the datapath's control pins of the same names.
REQ-008 SHALL have ports busy, done, div_zero (output, 1 each): operation in progress, one-cycle completion pulse, divide-by-zero flag.

Function
REQ-009 SHALL implement states IDLE, LOAD, SHIFT, SUB, TEST, DONE.
REQ-010 SHALL use this datapath contract: load=1 loads operands; shift=1 shifts {remainder,quotient} left one with inbit entering quotient[0]; add=1 strobes an ALU write selected by sel.
REQ-011 SHALL use this sel encoding: 00 remainder-=divisor; 01 remainder+=divisor (restore); 10 quotient[0]<=inbit; 11 reserved, never driven while add=1.
REQ-012 SHALL, in IDLE with start=1 and divisorin!=0, go to LOAD; with start=1 and divisorin==0, go to DONE with div_zero=1 and no datapath control asserted.
REQ-013 SHALL, in LOAD, assert load=1 for one cycle, clear the iteration counter, then go to SHIFT.
REQ-014 SHALL, in SHIFT, assert shift=1 with inbit=0 for one cycle, then go to SUB.
REQ-015 SHALL, in SUB, assert add=1, sel=00 for one cycle, then go to TEST.
REQ-016 SHALL, in TEST with sign=1, assert add=1, sel=01; with sign=0, assert add=1, sel=10, inbit=1.
REQ-017 SHALL, leaving TEST, increment the counter and go to SHIFT when fewer than NBITS iterations are complete, else go to DONE.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 SHALL hold div_zero from entry to DONE until the next start is accepted or reset.
REQ-020 SHALL assert busy in LOAD, SHIFT, SUB and TEST; deasserted in IDLE and DONE.
REQ-021 SHALL ignore start in every state except IDLE, including DONE.
REQ-022 SHALL, for NBITS=8, assert done in the 26th cycle after the edge sampling start (LOAD 1 cycle, 3 cycles per bit).
REQ-023 SHALL decode datapath controls combinationally from state (TEST also from sign); all other outputs SHALL be 0.
REQ-024 SHALL size the iteration counter to ceil(log2(NBITS+1)) bits with no wrap-around during an operation.

Reset
REQ-025 SHALL, with reset=1 at a rising edge, enter IDLE, clear counter and div_zero, regardless of state.
REQ-026 SHALL drive load, add, shift, inbit, busy, done, div_zero to 0 and sel to 00 during and after reset until start is accepted.
REQ-027 SHALL abandon an in-progress division on reset; datapath contents afterwards are don't-care.

Structure
REQ-028 SHALL take state encoding, sel encodings (SEL_SUB, SEL_ADD, SEL_SETQ) and default NBITS from shared package div_pkg, also used by the datapath and its bench.
REQ-029 SHALL be a single module with no sub-modules; integration with the datapath is done in a separate divider top.

Verification
REQ-030 SHALL cover: dividend 200, divisor 7, start pulse -> done at cycle 26, quotient 00011100, remainder 0000100, div_zero=0.
REQ-031 SHALL cover: dividend 255, divisor 1 -> quotient 11111111, remainder 0000000; TEST drives sel=10 in all 8 iterations.
REQ-032 SHALL cover: dividend 5, divisor 9 -> quotient 00000000, remainder 0000101; TEST drives sel=01 in all 8 iterations.
REQ-033 SHALL cover: divisor 0, start -> done and div_zero at cycle 1, load/add/shift never asserted.
REQ-034 SHALL cover: reset asserted during iteration 4 -> next cycle IDLE, all outputs 0; new start then completes a correct 200/7.
REQ-035 SHALL cover: start held high continuously -> back-to-back operations, start ignored while busy and in DONE, one done pulse per operation.
